// File: rtl/action_fsm_timed.sv
// action_fsm_timed
//   Per-player fencing action controller with per-state step timers, a health
//   counter with knockout, and a saturating score counter. The FSM advances only
//   on step_in (one strobe per frame from the game-state syncer). All outputs
//   are registered and reflect the step evaluated on the previous cycle.
//
// Ports
//   clk_pixel_in        pixel clock
//   rst_n_in            asynchronous active-low reset
//   step_in             evaluate FSM this cycle
//   block_in/lunge_in   held gestures
//   hit_in              attack path intersects opponent
//   parry_in            sabers colliding while opponent attacks
//   opponent_scored_in  opponent landed a touch this step
//   restart_in          leave KO and re-arm health/score
//   saber_state_out     00 rest, 01 lunge, 10 block, 11 attack
//   health_out          current health
//   score_out           current score (saturating)
//   player_scored_out   pulse with out_valid_out on a touch or parry
//   ko_out              high while knocked out
//   out_valid_out       pulse: outputs updated for this step
module action_fsm_timed #(
  parameter int HEALTH_W         = 3,
  parameter int HEALTH_INIT      = 5,
  parameter int SCORE_W          = 8,
  parameter int CNT_W            = 8,
  parameter int LUNGE_STEPS      = 4,
  parameter int ATTACK_MAX_STEPS = 30,
  parameter int BLOCK_MAX_STEPS  = 60,
  parameter int RECOVER_STEPS    = 15
) (
  input  logic                clk_pixel_in,
  input  logic                rst_n_in,
  input  logic                step_in,
  input  logic                block_in,
  input  logic                lunge_in,
  input  logic                hit_in,
  input  logic                parry_in,
  input  logic                opponent_scored_in,
  input  logic                restart_in,
  output logic [1:0]          saber_state_out,
  output logic [HEALTH_W-1:0] health_out,
  output logic [SCORE_W-1:0]  score_out,
  output logic                player_scored_out,
  output logic                ko_out,
  output logic                out_valid_out
);

  typedef enum logic [2:0] {
    S_REST, S_BLOCK, S_LUNGE, S_ATTACK, S_RECOVER, S_KO
  } state_e;

  // Expiry is the step that evaluates with timer == N-1.
  localparam logic [CNT_W-1:0]    LUNGE_LAST   = CNT_W'(LUNGE_STEPS - 1);
  localparam logic [CNT_W-1:0]    ATTACK_LAST  = CNT_W'(ATTACK_MAX_STEPS - 1);
  localparam logic [CNT_W-1:0]    BLOCK_LAST   = CNT_W'(BLOCK_MAX_STEPS - 1);
  localparam logic [CNT_W-1:0]    RECOVER_LAST = CNT_W'(RECOVER_STEPS - 1);
  localparam logic [HEALTH_W-1:0] HEALTH_RST   = HEALTH_W'(HEALTH_INIT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                scored_q, scored_d;
  logic                valid_q;
  logic                score_inc;
  logic                hurt;

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= S_REST;
      timer_q  <= '0;
      health_q <= HEALTH_RST;
      score_q  <= '0;
      scored_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      health_q <= health_d;
      score_q  <= score_d;
      scored_q <= scored_d;
      valid_q  <= step_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    health_d  = health_q;
    score_d   = score_q;
    scored_d  = 1'b0;
    score_inc = 1'b0;
    hurt      = 1'b0;
    if (step_in) begin
      // Opponent touches cost health everywhere except KO.
      if (state_q != S_KO && opponent_scored_in) begin
        hurt     = 1'b1;
        health_d = (health_q == '0) ? '0 : health_q - HEALTH_W'(1);
      end

      unique case (state_q)
        S_REST: begin
          if (block_in)      state_d = S_BLOCK;
          else if (lunge_in) state_d = S_LUNGE;
        end
        S_BLOCK: begin
          if (parry_in) begin
            score_inc = 1'b1;
            state_d   = S_RECOVER;
          end else if (!block_in) begin
            state_d = S_REST;
          end else if (timer_q == BLOCK_LAST) begin
            state_d = S_RECOVER;
          end
        end
        S_LUNGE: begin
          if (timer_q == LUNGE_LAST) state_d = S_ATTACK;
        end
        S_ATTACK: begin
          // A hit together with a non-lethal opponent touch is a double
          // touch: both counters move and we still recover.
          if (hit_in) begin
            score_inc = 1'b1;
            state_d   = S_RECOVER;
          end else if (hurt || !lunge_in || timer_q == ATTACK_LAST) begin
            state_d = S_RECOVER;
          end
        end
        S_RECOVER: begin
          if (timer_q == RECOVER_LAST) state_d = S_REST;
        end
        S_KO: begin
          if (restart_in) begin
            state_d  = S_REST;
            health_d = HEALTH_RST;
            score_d  = '0;
          end
        end
        default: state_d = S_REST;
      endcase

      // A lethal touch overrides everything, including a same-step hit.
      if (hurt && health_d == '0) begin
        state_d   = S_KO;
        score_inc = 1'b0;
      end

      if (score_inc) begin
        scored_d = 1'b1;
        if (score_q != '1) score_d = score_q + SCORE_W'(1);
      end

      if (state_d != state_q)  timer_d = '0;
      else if (timer_q != '1)  timer_d = timer_q + CNT_W'(1);
    end
  end

  always_comb begin
    saber_state_out = 2'b00;
    unique case (state_q)
      S_LUNGE:  saber_state_out = 2'b01;
      S_BLOCK:  saber_state_out = 2'b10;
      S_ATTACK: saber_state_out = 2'b11;
      default:  saber_state_out = 2'b00;
    endcase
  end

  assign health_out        = health_q;
  assign score_out         = score_q;
  assign player_scored_out = scored_q;
  assign ko_out            = (state_q == S_KO);
  assign out_valid_out     = valid_q;

endmodule

// File: tb/tb_action_fsm_timed.sv
module tb_action_fsm_timed;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step = 1'b0;
  logic       block_i = 1'b0, lunge_i = 1'b0, hit_i = 1'b0, parry_i = 1'b0;
  logic       opp_i = 1'b0, restart_i = 1'b0;
  logic [1:0] saber;
  logic [2:0] health;
  logic [7:0] score;
  logic       scored, ko, valid;

  int n_chk  = 0;
  int n_fail = 0;

  // Input bit masks for step()
  localparam logic [5:0] B = 6'b000001, L = 6'b000010, H = 6'b000100,
                         P = 6'b001000, O = 6'b010000, R = 6'b100000;

  typedef struct {
    logic [1:0] saber;
    logic [2:0] health;
    logic [7:0] score;
    logic       scored;
    logic       ko;
  } exp_t;

  exp_t exp_q[$];

  action_fsm_timed dut (
    .clk_pixel_in      (clk),
    .rst_n_in          (rst_n),
    .step_in           (step),
    .block_in          (block_i),
    .lunge_in          (lunge_i),
    .hit_in            (hit_i),
    .parry_in          (parry_i),
    .opponent_scored_in(opp_i),
    .restart_in        (restart_i),
    .saber_state_out   (saber),
    .health_out        (health),
    .score_out         (score),
    .player_scored_out (scored),
    .ko_out            (ko),
    .out_valid_out     (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("saber",  saber,  e.saber);
          chk("health", health, e.health);
          chk("score",  score,  e.score);
          chk("scored", scored, e.scored);
          chk("ko",     ko,     e.ko);
        end
      end else if (scored) begin
        chk("scored_without_valid", 1, 0);
      end
    end
  end

  // Drive one step starting on a negedge; returns on the next negedge.
  task automatic do_step(input logic [5:0] in, input logic [1:0] es, input int eh,
                         input int esc, input logic esd, input logic eko);
    exp_t e;
    e.saber = es; e.health = 3'(eh); e.score = 8'(esc); e.scored = esd; e.ko = eko;
    {restart_i, opp_i, parry_i, hit_i, lunge_i, block_i} = in;
    step = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    step = 1'b0;
    {restart_i, opp_i, parry_i, hit_i, lunge_i, block_i} = 6'b0;
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_saber",  saber,  0);
    chk("rst_health", health, 5);
    chk("rst_score",  score,  0);
    chk("rst_scored", scored, 0);
    chk("rst_ko",     ko,     0);
    chk("rst_valid",  valid,  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: lunge held through LUNGE, ATTACK (max), RECOVER, back to REST.
    do_reset();
    repeat (4)  do_step(L, 2'b01, 5, 0, 0, 0);
    repeat (30) do_step(L, 2'b11, 5, 0, 0, 0);
    repeat (16) do_step(L, 2'b00, 5, 0, 0, 0);
    do_step(L, 2'b01, 5, 0, 0, 0);

    // 2: hit in ATTACK; restart outside KO does nothing.
    do_reset();
    repeat (4) do_step(L, 2'b01, 5, 0, 0, 0);
    do_step(L,     2'b11, 5, 0, 0, 0);
    do_step(L | H, 2'b00, 5, 1, 1, 0);
    do_step(L | R, 2'b00, 5, 1, 0, 0);

    // 3: parry, release to REST, BLOCK max expiry.
    do_reset();
    do_step(B,     2'b10, 5, 0, 0, 0);
    do_step(B | P, 2'b00, 5, 1, 1, 0);
    repeat (15) do_step(B, 2'b00, 5, 1, 0, 0);
    do_step(B, 2'b10, 5, 1, 0, 0);
    do_step(0, 2'b00, 5, 1, 0, 0);
    do_step(B, 2'b10, 5, 1, 0, 0);
    repeat (59) do_step(B, 2'b10, 5, 1, 0, 0);
    do_step(B, 2'b00, 5, 1, 0, 0);
    do_step(B, 2'b00, 5, 1, 0, 0);

    // 4: knockout by five touches, inputs ignored, restart.
    do_reset();
    do_step(B,     2'b10, 5, 0, 0, 0);
    do_step(B | P, 2'b00, 5, 1, 1, 0);
    for (int h = 4; h >= 1; h--) do_step(O, 2'b00, h, 1, 0, 0);
    do_step(O,     2'b00, 0, 1, 0, 1);
    do_step(L,     2'b00, 0, 1, 0, 1);
    do_step(B,     2'b00, 0, 1, 0, 1);
    do_step(H | P, 2'b00, 0, 1, 0, 1);
    do_step(R,     2'b00, 5, 0, 0, 0);
    do_step(L,     2'b01, 5, 0, 0, 0);

    // 5: double touch, then lethal touch with a same-step hit.
    do_reset();
    do_step(L | O, 2'b01, 4, 0, 0, 0);
    do_step(L | O, 2'b01, 3, 0, 0, 0);
    repeat (2) do_step(L, 2'b01, 3, 0, 0, 0);
    do_step(L, 2'b11, 3, 0, 0, 0);
    do_step(L | H | O, 2'b00, 2, 1, 1, 0);
    do_step(O, 2'b00, 1, 1, 0, 0);
    repeat (14) do_step(0, 2'b00, 1, 1, 0, 0);
    repeat (4) do_step(L, 2'b01, 1, 1, 0, 0);
    do_step(L, 2'b11, 1, 1, 0, 0);
    do_step(L | H | O, 2'b00, 0, 1, 0, 1);
    do_step(L | B, 2'b00, 0, 1, 0, 1);

    // 6: reset mid-LUNGE, then idle cycles leave state frozen.
    do_reset();
    repeat (2) do_step(L, 2'b01, 5, 0, 0, 0);
    do_reset();
    repeat (3) begin
      @(negedge clk);
      chk("idle_saber", saber, 0);
      chk("idle_valid", valid, 0);
    end
    do_step(L, 2'b01, 5, 0, 0, 0);

    // 7: score saturates at 255 and the pulse still fires.
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      int s, sp;
      sp = (k - 1 > 255) ? 255 : k - 1;
      s  = (k > 255) ? 255 : k;
      do_step(B,     2'b10, 5, sp, 0, 0);
      do_step(B | P, 2'b00, 5, s,  1, 0);
      repeat (15) do_step(0, 2'b00, 5, s, 0, 0);
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
